// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU operation sequencer: ops, flag bit positions,
// branch-condition selects, FSM states and the latched execute context.
package alu_ctrl_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 3;
  localparam int unsigned NREG = 8;
  localparam int unsigned FW   = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_SAR = 3'd7;

  localparam int unsigned FL_C = 3;
  localparam int unsigned FL_V = 2;
  localparam int unsigned FL_N = 1;
  localparam int unsigned FL_Z = 0;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_Z  = 3'd1;
  localparam logic [2:0] COND_NZ = 3'd2;
  localparam logic [2:0] COND_N  = 3'd3;
  localparam logic [2:0] COND_NN = 3'd4;
  localparam logic [2:0] COND_C  = 3'd5;
  localparam logic [2:0] COND_V  = 3'd6;
  localparam logic [2:0] COND_LT = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Request fields that must survive from acceptance to write-back.
  typedef struct packed {
    logic [AW-1:0] dst;
    logic          fl_en;
    logic          cmp;
  } exec_ctx_t;

endpackage

// File: rtl/alu_ctrl_regfile.sv
// 8x16 register file: write-back/load arbitration, operand capture ports and
// an asynchronous debug read port.
module alu_ctrl_regfile
  import alu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_ld_en,
  input  logic [AW-1:0] i_ld_addr,
  input  logic [DW-1:0] i_ld_data,
  input  logic          i_cap_en,
  input  logic [AW-1:0] i_cap_a_addr,
  input  logic [AW-1:0] i_cap_b_addr,
  input  logic          i_cap_b_imm_en,
  input  logic [DW-1:0] i_cap_b_imm,
  output logic [DW-1:0] o_cap_a,
  output logic [DW-1:0] o_cap_b,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem [NREG];
  logic [DW-1:0] r_cap_a;
  logic [DW-1:0] r_cap_b;

  // Write-back takes priority over a host load to the same address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (i_wb_en && (i_wb_addr == AW'(i)))
          r_mem[i] <= i_wb_data;
        else if (i_ld_en && (i_ld_addr == AW'(i)))
          r_mem[i] <= i_ld_data;
      end
    end
  end

  // Operands sample pre-edge contents; no bypass from a same-cycle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_a <= '0;
      r_cap_b <= '0;
    end else if (i_cap_en) begin
      r_cap_a <= r_mem[i_cap_a_addr];
      r_cap_b <= i_cap_b_imm_en ? i_cap_b_imm : r_mem[i_cap_b_addr];
    end
  end

  assign o_cap_a   = r_cap_a;
  assign o_cap_b   = r_cap_b;
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/alu_ctrl.sv
// ALU operation sequencer: issues one instruction to the external ALU every
// three cycles and writes back. Optional ALU_CTRL_CMP_EN enables compare-only.
module alu_ctrl
  import alu_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_dst,
  input  logic [AW-1:0] req_src_a,
  input  logic [AW-1:0] req_src_b,
  input  logic          req_imm_en,
  input  logic [DW-1:0] req_imm,
  input  logic          req_fl_en,
  input  logic          req_cmp,
  output logic [2:0]    alu_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_result,
  input  logic [FW-1:0] alu_flags,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [FW-1:0] flags_q,
  input  logic [2:0]    cond_sel,
  output logic          cond_true,
  output logic          done
);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          w_accept;
  logic [2:0]    r_alu_sel;
  exec_ctx_t     r_ctx;
  logic [FW-1:0] r_flags;
  logic          w_wb_en;
  logic          w_wb_suppress;
  logic          w_cond;

  assign req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_sel <= '0;
      r_ctx     <= '0;
    end else if (w_accept) begin
      r_alu_sel <= req_op;
      r_ctx     <= '{dst: req_dst, fl_en: req_fl_en, cmp: req_cmp};
    end
  end

`ifdef ALU_CTRL_CMP_EN
  assign w_wb_suppress = r_ctx.cmp;
`else
  logic w_unused_cmp;
  assign w_unused_cmp  = r_ctx.cmp;
  assign w_wb_suppress = 1'b0;
`endif

  assign w_wb_en = (r_state == ST_EXEC) && !w_wb_suppress;

  always_ff @(posedge clk) begin
    if (rst)                                      r_flags <= '0;
    else if ((r_state == ST_EXEC) && r_ctx.fl_en) r_flags <= alu_flags;
  end

  alu_ctrl_regfile u_regfile (
    .clk            (clk),
    .rst            (rst),
    .i_wb_en        (w_wb_en),
    .i_wb_addr      (r_ctx.dst),
    .i_wb_data      (alu_result),
    .i_ld_en        (ld_en),
    .i_ld_addr      (ld_addr),
    .i_ld_data      (ld_data),
    .i_cap_en       (w_accept),
    .i_cap_a_addr   (req_src_a),
    .i_cap_b_addr   (req_src_b),
    .i_cap_b_imm_en (req_imm_en),
    .i_cap_b_imm    (req_imm),
    .o_cap_a        (alu_a),
    .o_cap_b        (alu_b),
    .i_rd_addr      (rd_addr),
    .o_rd_data      (rd_data)
  );

  // Branch condition evaluated on the stored flags.
  always_comb begin
    w_cond = 1'b1;
    case (cond_sel)
      COND_AL: w_cond = 1'b1;
      COND_Z:  w_cond = r_flags[FL_Z];
      COND_NZ: w_cond = !r_flags[FL_Z];
      COND_N:  w_cond = r_flags[FL_N];
      COND_NN: w_cond = !r_flags[FL_N];
      COND_C:  w_cond = r_flags[FL_C];
      COND_V:  w_cond = r_flags[FL_V];
      COND_LT: w_cond = r_flags[FL_N] ^ r_flags[FL_V];
      default: w_cond = 1'b1;
    endcase
  end

  assign alu_sel   = r_alu_sel;
  assign flags_q   = r_flags;
  assign cond_true = w_cond;
  assign done      = (r_state == ST_DONE);

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

ALU operation sequencer sitting on the control side of the 16-bit combinational ALU. Accepts one ALU instruction per handshake, reads operands from an internal 8×16 register file, drives the ALU select and operand ports, captures result and flags, writes back, and exposes the stored flags through a branch-condition evaluator. It is the issuing and consuming end of the ALU interface and replaces ad-hoc operand muxing in the CPU core.

## Interface
- No parameters. Data width is fixed at 16 and register count at 8.
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  instruction request valid
- `req_ready`  out  1  block can accept a request
- `req_op`  in  3  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 SAR
- `req_dst`, `req_src_a`, `req_src_b`  in  3 each  register indices
- `req_imm_en`  in  1  when 1, B operand is `req_imm`, not `src_b`
- `req_imm`  in  16  immediate operand
- `req_fl_en`  in  1  when 1, update the flag register
- `req_cmp`  in  1  compare-only request; see Configuration
- `alu_sel`  out  3  to ALU select
- `alu_a`, `alu_b`  out  16  to ALU operands
- `alu_result`  in  16  from ALU
- `alu_flags`  in  4  from ALU, {carry, overflow, negative, zero}
- `ld_en`, `ld_addr[2:0]`, `ld_data[15:0]`  in  host register load port
- `rd_addr`  in  3, `rd_data`  out  16  asynchronous debug read port
- `flags_q`  out  4  stored flags, same bit order as `alu_flags`
- `cond_sel`  in  3, `cond_true`  out  1  combinational condition on `flags_q`
- `done`  out  1  one-cycle pulse at write-back completion

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE → EXEC when `req_valid && req_ready`.
  - At that edge: latch `alu_sel`. Latch `alu_a` from `src_a`. Latch `alu_b` from `src_b`, or from `req_imm` when `imm_en`. Latch `dst`, `fl_en` and `cmp`.
- EXEC → DONE unconditionally.
  - At that edge: write `alu_result` to `dst`, unless the request is compare-only.
  - If `fl_en`, set `flags_q` to `alu_flags`.
- DONE → IDLE unconditionally. `done` is 1 only in DONE.
- `req_ready` = 1 only in IDLE and not in reset. Requests are not queued.
- The block passes `alu_flags` through unmodified. Carry and overflow from logic and shift ops are whatever the ALU reports.
- `cond_sel` encoding:
  - 0: always
  - 1: Z
  - 2: !Z
  - 3: N
  - 4: !N
  - 5: C
  - 6: V
  - 7: N^V (signed less-than)
- No register is hardwired to zero.
- Load port:
  - `ld_en` writes on any cycle.
  - If the EXEC write-back and `ld_en` target the same address in the same cycle, write-back wins.
  - If they target different addresses, both writes happen.
- Operand read at acceptance sees pre-edge register contents. There is no bypass from a same-cycle `ld_en`.

## Timing
- Accept at edge T → EXEC during cycle T..T+1 → write-back and flags at edge T+1 → `done` high during cycle T+1..T+2 → IDLE at T+2.
- Latency from acceptance to `done` is 1 cycle. Throughput is one op per 3 cycles.
- `alu_sel`, `alu_a` and `alu_b` are registered and hold their value until the next acceptance, so the ALU has one full cycle.
- Reset values:
  - state IDLE
  - `req_ready` 0 while `rst` is high, 1 on the first cycle after
  - `alu_sel`, `alu_a`, `alu_b` = 0
  - all registers = 0
  - `flags_q` = 0
  - `done` = 0
- Reset in EXEC or DONE aborts the operation: no write-back, no flag update, no `done`.
- `ld_en` is ignored while `rst` is high.

## Configuration
- `ALU_CTRL_CMP_EN` defined: `req_cmp` = 1 suppresses the register write-back. Flags still update per `req_fl_en`. `done` still pulses.
- Macro undefined: `req_cmp` is ignored and every request writes back.
- The port exists in both builds.

## Structure
- Package `alu_ctrl_pkg` holds:
  - op encodings
  - flag bit indices (C=3, V=2, N=1, Z=0)
  - `cond_sel` encodings
  - FSM state enum
- Sub-module `alu_ctrl_regfile`: 8×16 storage, two synchronous-capture read ports for operands, the asynchronous debug read port, and write arbitration with write-back priority.
- The ALU is instantiated by the parent, not inside this block.

## Test plan
- **Overflow add:** load r1=0x7FFF, r2=0x0001; ADD dst r3, fl_en=1 → r3=0x8000, `flags_q`=4'b0110, `done` exactly 1 cycle after acceptance, `cond_true` for sel 7 = 0.
- **Borrow subtract:** r0=0x0000, r4=0x0001; SUB dst r5 → r5=0xFFFF, `flags_q`=4'b1010, `cond_sel`=5 true, `cond_sel`=2 true.
- **Immediate shift, flags held:** r1=0x0001; SHL imm 4, fl_en=0 → r1=0x0010, `flags_q` unchanged from the previous op.
- **Back-to-back:** `req_valid` held high for 3 ops → accepted every 3rd cycle, `req_ready` low in EXEC and DONE, 3 `done` pulses.
- **Reset mid-operation:** `rst` pulsed during EXEC of ADD to r6 → r6=0, `flags_q`=0, no `done`, `req_ready`=1 the cycle after reset.
- **Compare and write collision:** with `ALU_CTRL_CMP_EN`, SUB cmp=1 with r2=r3=0x1234 → dst unchanged, Z=1. Then `ld_en` to r3 in the same cycle as a write-back to r3 → the write-back value is stored.
